// File: rtl/evstat_wb_poller_if.sv
// -----------------------------------------------------------------------------
// evstat_wb_poller_if
//
// Wishbone bus bundle between the event-statistics poller (master) and the
// statistics register slaves: 8-bit data, 16-bit address, single-byte reads.
// Signal names are kept from the master's point of view so that the poller's
// original port names survive the move into an interface.
//
// Signals:
//   cyc_o  - bus cycle            (master -> slave)
//   stb_o  - strobe               (master -> slave)
//   wr_o   - write enable, always 0 from the poller
//   adr_o  - 16-bit address       (master -> slave)
//   dat_o  - write data, always 0 from the poller
//   dat_i  - read data            (slave -> master)
//   ack_i  - acknowledge          (slave -> master)
//   err_i  - error                (slave -> master)
//   rty_i  - retry                (slave -> master)
// -----------------------------------------------------------------------------
interface evstat_wb_poller_if;
    logic        cyc_o;
    logic        stb_o;
    logic        wr_o;
    logic [15:0] adr_o;
    logic [7:0]  dat_o;
    logic [7:0]  dat_i;
    logic        ack_i;
    logic        err_i;
    logic        rty_i;

    modport master (
        output cyc_o, stb_o, wr_o, adr_o, dat_o,
        input  dat_i, ack_i, err_i, rty_i
    );

    modport slave (
        input  cyc_o, stb_o, wr_o, adr_o, dat_o,
        output dat_i, ack_i, err_i, rty_i
    );
endinterface

// File: rtl/evstat_wb_poller.sv
// -----------------------------------------------------------------------------
// evstat_wb_poller
//
// Wishbone master that sweeps the event-readout statistics window once per
// start request (single-byte reads from BASE_ADR .. BASE_ADR+NUM_REGS-1) and
// streams the bytes out as one framed record on a valid/ready byte stream.
// Only one bus access is outstanding at a time and the next read is issued
// only after the previous byte is accepted, so stream backpressure stalls the
// bus instead of dropping data. Failed reads still produce a byte:
// err -> 8'hEE, retries exhausted -> 8'hEE, no response -> 8'hFF.
//
// Build option:
//   EVSTAT_SEQ_HEADER_EN - when defined, every record is prefixed by an 8-bit
//                          wrapping sequence number (NUM_REGS+1 bytes total).
//                          Undefined: no header, no sequence counter.
//
// Parameters:
//   BASE_ADR  - first register address read
//   NUM_REGS  - number of consecutive bytes read (1..32)
//   TIMEOUT   - strobed cycles without response before giving up (1..255)
//   MAX_RETRY - re-issues allowed on rty per address
//
// Ports:
//   clk_i        - clock (bus and stream)
//   rst_n_i      - asynchronous active-low reset
//   start_i      - one-cycle sweep request
//   wb           - wishbone master side (evstat_wb_poller_if.master)
//   rec_dat_o    - record byte
//   rec_valid_o  - record byte valid
//   rec_ready_i  - downstream accepts the byte
//   rec_last_o   - current byte is the last of the record
//   busy_o       - sweep in progress
//   done_o       - one-cycle pulse when the sweep completes
//   status_o     - sticky {overrun, retry_exhausted, timeout, bus_err},
//                  cleared by an accepted start
// -----------------------------------------------------------------------------
module evstat_wb_poller #(
    parameter logic [15:0] BASE_ADR  = 16'h0080,
    parameter int unsigned NUM_REGS  = 16,
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_i,
    evstat_wb_poller_if.master wb,
    output logic [7:0]         rec_dat_o,
    output logic               rec_valid_o,
    input  logic               rec_ready_i,
    output logic               rec_last_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [3:0]         status_o
);

    localparam logic [2:0] IDLE = 3'd0;
`ifdef EVSTAT_SEQ_HEADER_EN
    localparam logic [2:0] HDR  = 3'd1;
`endif
    localparam logic [2:0] REQ  = 3'd2;
    localparam logic [2:0] OUT  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    localparam logic [5:0] LAST_IDX  = 6'(NUM_REGS - 1);
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
    localparam logic [7:0] RETRY_C   = 8'(MAX_RETRY);

    // status_o bit positions
    localparam int unsigned ST_BUS_ERR = 0;
    localparam int unsigned ST_TMO     = 1;
    localparam int unsigned ST_RTX     = 2;
    localparam int unsigned ST_OVR     = 3;

    logic [2:0]  state;
    logic [5:0]  idx;
    logic [7:0]  retry_cnt;
    logic [7:0]  tmo_cnt;
`ifdef EVSTAT_SEQ_HEADER_EN
    logic [7:0]  seq;
`endif

    logic        is_last;
    logic [15:0] next_adr;
    logic        resp_done;
    logic [7:0]  resp_byte;
    logic        set_err;
    logic        set_rtx;
    logic        set_tmo;
    logic        reissue;

    assign wb.wr_o  = 1'b0;
    assign wb.dat_o = '0;

    assign is_last  = (idx == LAST_IDX);
    assign next_adr = BASE_ADR + {10'd0, 6'(idx + 6'd1)};

    // Outcome of the strobed cycle being sampled on this edge.
    // Priority ack > err > rty > timeout.
    always_comb begin
        resp_done = 1'b0;
        resp_byte = wb.dat_i;
        set_err   = 1'b0;
        set_rtx   = 1'b0;
        set_tmo   = 1'b0;
        reissue   = 1'b0;
        if (state == REQ && wb.stb_o) begin
            if (wb.ack_i) begin
                resp_done = 1'b1;
            end else if (wb.err_i) begin
                resp_done = 1'b1;
                resp_byte = 8'hEE;
                set_err   = 1'b1;
            end else if (wb.rty_i) begin
                if (retry_cnt == RETRY_C) begin
                    resp_done = 1'b1;
                    resp_byte = 8'hEE;
                    set_rtx   = 1'b1;
                end else begin
                    reissue = 1'b1;
                end
            end else if (8'(tmo_cnt + 8'd1) == TIMEOUT_C) begin
                resp_done = 1'b1;
                resp_byte = 8'hFF;
                set_tmo   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            idx         <= '0;
            retry_cnt   <= '0;
            tmo_cnt     <= '0;
`ifdef EVSTAT_SEQ_HEADER_EN
            seq         <= '0;
`endif
            wb.cyc_o    <= 1'b0;
            wb.stb_o    <= 1'b0;
            wb.adr_o    <= '0;
            rec_dat_o   <= '0;
            rec_valid_o <= 1'b0;
            rec_last_o  <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            status_o    <= '0;
        end else begin
            done_o <= 1'b0;

            if (start_i && busy_o) begin
                status_o[ST_OVR] <= 1'b1;
            end

            case (state)
                // DONE already has busy_o low, so a start landing on the
                // done cycle is treated exactly like one arriving in IDLE.
                IDLE, DONE: begin
                    state <= IDLE;
                    if (start_i) begin
                        status_o  <= '0;
                        idx       <= '0;
                        retry_cnt <= '0;
                        tmo_cnt   <= '0;
                        busy_o    <= 1'b1;
                        wb.adr_o  <= BASE_ADR;
`ifdef EVSTAT_SEQ_HEADER_EN
                        rec_dat_o   <= seq;
                        rec_valid_o <= 1'b1;
                        rec_last_o  <= 1'b0;
                        state       <= HDR;
`else
                        wb.cyc_o <= 1'b1;
                        wb.stb_o <= 1'b1;
                        state    <= REQ;
`endif
                    end
                end

`ifdef EVSTAT_SEQ_HEADER_EN
                HDR: begin
                    if (rec_ready_i) begin
                        rec_valid_o <= 1'b0;
                        seq         <= seq + 8'd1;
                        wb.cyc_o    <= 1'b1;
                        wb.stb_o    <= 1'b1;
                        state       <= REQ;
                    end
                end
`endif

                REQ: begin
                    if (!wb.stb_o) begin
                        // idle cycle after a retry: re-issue the same address
                        wb.cyc_o <= 1'b1;
                        wb.stb_o <= 1'b1;
                    end else if (resp_done) begin
                        wb.cyc_o    <= 1'b0;
                        wb.stb_o    <= 1'b0;
                        rec_dat_o   <= resp_byte;
                        rec_valid_o <= 1'b1;
                        rec_last_o  <= is_last;
                        if (set_err) status_o[ST_BUS_ERR] <= 1'b1;
                        if (set_rtx) status_o[ST_RTX]     <= 1'b1;
                        if (set_tmo) status_o[ST_TMO]     <= 1'b1;
                        state <= OUT;
                    end else if (reissue) begin
                        wb.cyc_o  <= 1'b0;
                        wb.stb_o  <= 1'b0;
                        retry_cnt <= retry_cnt + 8'd1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end

                OUT: begin
                    if (rec_ready_i) begin
                        rec_valid_o <= 1'b0;
                        rec_last_o  <= 1'b0;
                        if (is_last) begin
                            done_o <= 1'b1;
                            busy_o <= 1'b0;
                            state  <= DONE;
                        end else begin
                            idx       <= 6'(idx + 6'd1);
                            retry_cnt <= '0;
                            tmo_cnt   <= '0;
                            wb.adr_o  <= next_adr;
                            wb.cyc_o  <= 1'b1;
                            wb.stb_o  <= 1'b1;
                            state     <= REQ;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_evstat_wb_poller.sv
`timescale 1ns/1ps
module tb_evstat_wb_poller;

    localparam logic [15:0] BASE = 16'h0080;
    localparam int unsigned NREG = 16;
    localparam int unsigned TMO  = 255;
    localparam int unsigned MRTY = 3;
`ifdef EVSTAT_SEQ_HEADER_EN
    localparam int unsigned HDR = 1;
`else
    localparam int unsigned HDR = 0;
`endif

    localparam int unsigned M_ACK  = 0;
    localparam int unsigned M_ERR  = 1;
    localparam int unsigned M_RTY  = 2;
    localparam int unsigned M_NONE = 3;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       start     = 1'b0;
    logic       rec_ready = 1'b0;
    logic [7:0] rec_dat;
    logic       rec_valid;
    logic       rec_last;
    logic       busy;
    logic       done;
    logic [3:0] status;

    evstat_wb_poller_if wb ();

    evstat_wb_poller #(
        .BASE_ADR (BASE),
        .NUM_REGS (NREG),
        .TIMEOUT  (TMO),
        .MAX_RETRY(MRTY)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .start_i    (start),
        .wb         (wb.master),
        .rec_dat_o  (rec_dat),
        .rec_valid_o(rec_valid),
        .rec_ready_i(rec_ready),
        .rec_last_o (rec_last),
        .busy_o     (busy),
        .done_o     (done),
        .status_o   (status)
    );

    always #5 clk = ~clk;

    int nchecks = 0;
    int nerrs   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- slave model ----------------
    int unsigned cfg_mode [NREG];
    int unsigned cfg_lat  [NREG];
    int unsigned cfg_nrty [NREG];
    logic [7:0]  cfg_dat  [NREG];
    int unsigned rty_seen [NREG];
    int unsigned sw;
    logic        slv_clr = 1'b0;
    logic [3:0]  soff;
    logic        hit;

    assign soff = 4'(wb.adr_o - BASE);
    assign hit  = wb.cyc_o && wb.stb_o && (sw == cfg_lat[soff]);
    assign wb.ack_i = hit && (cfg_mode[soff] == M_ACK ||
                              (cfg_mode[soff] == M_RTY && rty_seen[soff] >= cfg_nrty[soff]));
    assign wb.err_i = hit && (cfg_mode[soff] == M_ERR);
    assign wb.rty_i = hit && (cfg_mode[soff] == M_RTY) && (rty_seen[soff] < cfg_nrty[soff]);
    assign wb.dat_i = wb.ack_i ? cfg_dat[soff] : 8'h5A;

    always @(posedge clk) begin
        if (slv_clr) begin
            for (int i = 0; i < NREG; i++) rty_seen[i] <= 0;
            sw <= 0;
        end else if (!wb.stb_o) begin
            sw <= 0;
        end else if (wb.ack_i || wb.err_i || wb.rty_i) begin
            sw <= 0;
            if (wb.rty_i) rty_seen[soff] <= rty_seen[soff] + 1;
        end else begin
            sw <= sw + 1;
        end
    end

    // ---------------- stream monitor / ready driver ----------------
    logic [7:0]  got_q  [$];
    bit          lastq  [$];
    int unsigned rdy_mode   = 0;
    int unsigned stall_left = 0;
    bit          prev_hold  = 0;
    logic [7:0]  prev_dat;
    logic        prev_last;
    int unsigned run = 0;
    logic [3:0]  run_off;
    int unsigned last_run [NREG];

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 0;
            run       = 0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", rec_valid, 1);
                check("hold_dat", rec_dat, prev_dat);
                check("hold_last", rec_last, prev_last);
            end
            if (rec_valid) check("bus_idle_while_valid", wb.cyc_o | wb.stb_o, 0);
            if (wb.stb_o) begin
                run++;
                run_off = soff;
            end else if (run != 0) begin
                last_run[run_off] = run;
                run = 0;
            end
            case (rdy_mode)
                0: rec_ready = 1'b1;
                1: rec_ready = ($urandom_range(3) != 0);
                default: begin
                    if (rec_valid && got_q.size() == 3 + HDR && stall_left != 0) begin
                        rec_ready = 1'b0;
                        stall_left--;
                    end else begin
                        rec_ready = 1'b1;
                    end
                end
            endcase
            if (rec_valid && rec_ready) begin
                got_q.push_back(rec_dat);
                lastq.push_back(rec_last);
            end
            prev_hold = rec_valid && !rec_ready;
            prev_dat  = rec_dat;
            prev_last = rec_last;
        end
    end

    // ---------------- configuration helpers ----------------
    task automatic cfg_plain();
        for (int i = 0; i < NREG; i++) begin
            cfg_mode[i] = M_ACK;
            cfg_lat[i]  = 0;
            cfg_nrty[i] = 0;
            cfg_dat[i]  = 8'(BASE + 16'(i));
        end
    endtask

    task automatic cfg_random();
        int unsigned r;
        for (int i = 0; i < NREG; i++) begin
            r = $urandom_range(15);
            cfg_mode[i] = (r < 9) ? M_ACK : (r < 11) ? M_ERR : (r < 15) ? M_RTY : M_NONE;
            cfg_lat[i]  = $urandom_range(2);
            cfg_nrty[i] = $urandom_range(5);
            cfg_dat[i]  = 8'($urandom);
        end
    endtask

    // ---------------- reference model + sweep ----------------
    logic [7:0] seq_model = 8'd0;

    task automatic sweep(input int unsigned rmode, input int unsigned mid_start_at, input bit timing);
        logic [7:0]  exp_q [$];
        logic [3:0]  exp_st;
        int unsigned cnt;
        bit          seen_done;
        int unsigned n;

        exp_st = 4'b0000;
        if (HDR != 0) exp_q.push_back(seq_model);
        for (int i = 0; i < NREG; i++) begin
            case (cfg_mode[i])
                M_ACK: exp_q.push_back(cfg_dat[i]);
                M_ERR: begin exp_q.push_back(8'hEE); exp_st[0] = 1'b1; end
                M_RTY: begin
                    if (cfg_nrty[i] > MRTY) begin
                        exp_q.push_back(8'hEE);
                        exp_st[2] = 1'b1;
                    end else begin
                        exp_q.push_back(cfg_dat[i]);
                    end
                end
                default: begin exp_q.push_back(8'hFF); exp_st[1] = 1'b1; end
            endcase
        end
        if (mid_start_at != 0) exp_st[3] = 1'b1;

        got_q.delete();
        lastq.delete();
        rdy_mode   = rmode;
        stall_left = 10;

        @(negedge clk);
        start   = 1'b1;
        slv_clr = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        slv_clr = 1'b0;
        check("busy_after_start", busy, 1);
        if (timing) check("first_cycle_out", (HDR != 0) ? rec_valid : wb.stb_o, 1);

        cnt = 1;
        seen_done = 0;
        while (!seen_done && cnt < 20000) begin
            @(negedge clk);
            cnt++;
            start = (cnt == mid_start_at);
            if (done) seen_done = 1;
        end
        start = 1'b0;
        check("done_seen", seen_done, 1);
        if (timing) check("done_cycle", cnt, 2 * NREG + 1 + HDR);
        check("busy_at_done", busy, 0);
        check("status", status, exp_st);
        check("rec_len", got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("rec_byte%0d", i), got_q[i], exp_q[i]);
            check($sformatf("rec_last%0d", i), lastq[i], (i == exp_q.size() - 1));
        end
        seq_model = seq_model + 8'd1;
        @(negedge clk);
        check("done_pulse_end", done, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int unsigned n;
        cfg_plain();
        for (int i = 0; i < NREG; i++) last_run[i] = 0;
        repeat (3) @(negedge clk);
        check("rst_cyc", wb.cyc_o, 0);
        check("rst_stb", wb.stb_o, 0);
        check("rst_wr", wb.wr_o, 0);
        check("rst_adr", wb.adr_o, 0);
        check("rst_dat_o", wb.dat_o, 0);
        check("rst_valid", rec_valid, 0);
        check("rst_rec_dat", rec_dat, 0);
        check("rst_last", rec_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_status", status, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // straight sweep, full throughput
        cfg_plain();
        sweep(0, 0, 1);

        // 10-cycle stall on data byte 3
        cfg_plain();
        sweep(2, 0, 0);

        // err, retry exhaustion and timeout in one sweep
        cfg_plain();
        cfg_mode[4] = M_ERR;
        cfg_mode[6] = M_RTY;
        cfg_nrty[6] = 4;
        cfg_mode[8] = M_NONE;
        sweep(0, 0, 0);
        check("timeout_strobe_len", last_run[8], TMO);
        check("ack_strobe_len", last_run[0], 1);

        // start while busy -> overrun, then random sweeps clear it
        cfg_random();
        sweep(1, 5, 0);
        for (int unsigned k = 0; k < 4; k++) begin
            cfg_random();
            sweep(1, 0, 0);
        end

        // reset in the middle of a sweep
        cfg_plain();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(wb.stb_o && n >= 4) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_wait_stb", wb.stb_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_cyc", wb.cyc_o, 0);
        check("arst_stb", wb.stb_o, 0);
        check("arst_busy", busy, 0);
        check("arst_valid", rec_valid, 0);
        check("arst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seq_model = 8'd0;
        @(negedge clk);
        sweep(0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", nchecks, nerrs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
